// File: rtl/rv_exec_unit.sv
// RV32/RV64 integer execute stage: register file, single-cycle ALU/branch/load/store
// address path, and an optional iterative multiply/divide engine behind an issue handshake.
module rv_exec_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] alu_output,
    output logic            branch_taken,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam int RIW = $clog2(NUM_REGS);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_reg, state_next;

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] acc_reg, lo_reg, opb_reg, dvd_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      m_f3_reg;
    logic [4:0]      m_rd_reg;
    logic            neg_reg, neg_r_reg, dz_reg;
    logic            wb_valid_reg;
    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;

    logic [XLEN-1:0] opb, alu_res, load_val, sra_res;
    logic [SHW-1:0]  shamt;
    logic            enc_ok, wr_single, is_m, br_cond, bad_index, sh_lsb_ok, f7_ok;
    logic            accept, wr_en;
    logic [4:0]      wr_idx;
    logic [XLEN-1:0] wr_val;

    assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1[RIW-1:0]];
    assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2[RIW-1:0]];

    // RV32E decodes only 16 registers; the fifth index bit is an encoding error.
    assign bad_index = (NUM_REGS == 16) && (rd[4] || rs1[4] || rs2[4]);
    assign sh_lsb_ok = (XLEN == 64) || !funct7[0];
    assign f7_ok     = (opcode == OP_IMM) || (funct7 == 7'd0);

    always_comb begin
        enc_ok    = 1'b0;
        wr_single = 1'b0;
        is_m      = 1'b0;
        alu_res   = '0;
        load_val  = '0;
        br_cond   = 1'b0;
        opb       = (opcode == OP_REG) ? rs2_data : imm;
        shamt     = opb[SHW-1:0];
        sra_res   = $signed(rs1_data) >>> shamt;
        case (opcode)
            OP_LUI:   begin enc_ok = 1'b1; wr_single = 1'b1; alu_res = imm; end
            OP_AUIPC: begin enc_ok = 1'b1; wr_single = 1'b1; alu_res = pc + imm; end
            OP_JAL:   begin enc_ok = 1'b1; wr_single = 1'b1; alu_res = pc + XLEN'(4); end
            OP_JALR:  begin enc_ok = (funct3 == 3'd0); wr_single = 1'b1; alu_res = pc + XLEN'(4); end
            OP_BRANCH: begin
                enc_ok  = (funct3 != 3'd2) && (funct3 != 3'd3);
                alu_res = pc + imm;
                case (funct3)
                    3'd0:    br_cond = (rs1_data == rs2_data);
                    3'd1:    br_cond = (rs1_data != rs2_data);
                    3'd4:    br_cond = ($signed(rs1_data) <  $signed(rs2_data));
                    3'd5:    br_cond = ($signed(rs1_data) >= $signed(rs2_data));
                    3'd6:    br_cond = (rs1_data <  rs2_data);
                    3'd7:    br_cond = (rs1_data >= rs2_data);
                    default: br_cond = 1'b0;
                endcase
            end
            OP_LOAD: begin
                alu_res   = rs1_data + imm;
                wr_single = 1'b1;
                case (funct3)
                    3'd0: begin enc_ok = 1'b1; load_val = XLEN'($signed(read_data[7:0])); end
                    3'd1: begin enc_ok = 1'b1; load_val = XLEN'($signed(read_data[15:0])); end
                    3'd2: begin enc_ok = 1'b1; load_val = XLEN'($signed(read_data[31:0])); end
                    3'd3: begin enc_ok = (XLEN == 64); load_val = read_data; end
                    3'd4: begin enc_ok = 1'b1; load_val = XLEN'(read_data[7:0]); end
                    3'd5: begin enc_ok = 1'b1; load_val = XLEN'(read_data[15:0]); end
                    3'd6: begin enc_ok = (XLEN == 64); load_val = XLEN'(read_data[31:0]); end
                    default: enc_ok = 1'b0;
                endcase
            end
            OP_STORE: begin
                alu_res = rs1_data + imm;
                enc_ok  = (funct3 <= 3'd2) || ((funct3 == 3'd3) && (XLEN == 64));
            end
            OP_IMM, OP_REG: begin
                if (opcode == OP_REG && funct7 == F7_MULDIV) begin
                    is_m   = 1'b1;
                    enc_ok = (ENABLE_M != 0);
                end else begin
                    wr_single = 1'b1;
                    case (funct3)
                        3'd0: begin
                            if (opcode == OP_REG && funct7 == F7_ALT) begin
                                enc_ok  = 1'b1;
                                alu_res = rs1_data - opb;
                            end else begin
                                enc_ok  = f7_ok;
                                alu_res = rs1_data + opb;
                            end
                        end
                        3'd1: begin
                            enc_ok  = (opcode == OP_REG) ? (funct7 == 7'd0)
                                                         : (sh_lsb_ok && funct7[6:1] == 6'd0);
                            alu_res = rs1_data << shamt;
                        end
                        3'd2: begin enc_ok = f7_ok; alu_res = XLEN'($signed(rs1_data) < $signed(opb)); end
                        3'd3: begin enc_ok = f7_ok; alu_res = XLEN'(rs1_data < opb); end
                        3'd4: begin enc_ok = f7_ok; alu_res = rs1_data ^ opb; end
                        3'd5: begin
                            if (opcode == OP_REG)
                                enc_ok = (funct7 == 7'd0) || (funct7 == F7_ALT);
                            else
                                enc_ok = sh_lsb_ok && (funct7[6:1] == 6'd0 || funct7[6:1] == 6'b010000);
                            alu_res = funct7[5] ? sra_res : (rs1_data >> shamt);
                        end
                        3'd6: begin enc_ok = f7_ok; alu_res = rs1_data | opb; end
                        default: begin enc_ok = f7_ok; alu_res = rs1_data & opb; end
                    endcase
                end
            end
            default: enc_ok = 1'b0;
        endcase
    end

    assign illegal      = issue_valid && (!enc_ok || bad_index);
    assign alu_output   = (enc_ok && !bad_index) ? alu_res : '0;
    assign branch_taken = (opcode == OP_BRANCH) && br_cond;
    assign issue_ready  = (state_reg == IDLE);
    assign busy         = (state_reg == MUL) || (state_reg == DIV);
    assign accept       = issue_valid && issue_ready && enc_ok && !bad_index;

    // Operands enter the engine as magnitudes; the sign is restored when the result is taken.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign a_neg    = a_signed && rs1_data[XLEN-1];
    assign b_neg    = b_signed && rs2_data[XLEN-1];
    assign a_mag    = a_neg ? -rs1_data : rs1_data;
    assign b_mag    = b_neg ? -rs2_data : rs2_data;

    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, m_result;
    assign mul_sum  = {1'b0, acc_reg} + {1'b0, (lo_reg[0] ? opb_reg : '0)};
    assign rem_sh   = {acc_reg, lo_reg[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, opb_reg};
    assign prod     = {acc_reg, lo_reg};
    assign prod_s   = neg_reg ? -prod : prod;
    assign quo_s    = neg_reg ? -lo_reg : lo_reg;
    assign rem_s    = neg_r_reg ? -acc_reg : acc_reg;

    always_comb begin
        m_result = '0;
        case (m_f3_reg)
            3'd0:       m_result = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       m_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: m_result = dz_reg ? '1 : quo_s;
            default:    m_result = dz_reg ? dvd_reg : rem_s;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept && is_m) state_next = funct3[2] ? DIV : MUL;
            MUL, DIV: if (cnt_reg == '0) state_next = DONE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            lo_reg    <= '0;
            opb_reg   <= '0;
            dvd_reg   <= '0;
            cnt_reg   <= '0;
            m_f3_reg  <= '0;
            m_rd_reg  <= '0;
            neg_reg   <= 1'b0;
            neg_r_reg <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept && is_m) begin
                acc_reg   <= '0;
                lo_reg    <= funct3[2] ? a_mag : b_mag;
                opb_reg   <= funct3[2] ? b_mag : a_mag;
                dvd_reg   <= rs1_data;
                cnt_reg   <= CW'(XLEN - 1);
                m_f3_reg  <= funct3;
                m_rd_reg  <= rd;
                neg_reg   <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
                dz_reg    <= (rs2_data == '0);
            end else if (state_reg == MUL) begin
                acc_reg <= mul_sum[XLEN:1];
                lo_reg  <= {mul_sum[0], lo_reg[XLEN-1:1]};
                cnt_reg <= cnt_reg - CW'(1);
            end else if (state_reg == DIV) begin
                acc_reg <= div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                lo_reg  <= {lo_reg[XLEN-2:0], ~div_diff[XLEN]};
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end

    assign wr_en  = (accept && wr_single) || (state_reg == DONE);
    assign wr_idx = (state_reg == DONE) ? m_rd_reg : rd;
    assign wr_val = (state_reg == DONE) ? m_result : ((opcode == OP_LOAD) ? load_val : alu_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else begin
            wb_valid_reg <= wr_en && (wr_idx != 5'd0);
            if (wr_en && wr_idx != 5'd0) begin
                regs[wr_idx[RIW-1:0]] <= wr_val;
                wb_rd_reg             <= wr_idx;
                wb_data_reg           <= wr_val;
            end
        end
    end

    assign wb_valid = wb_valid_reg;
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;
endmodule

// File: tb/tb_rv_exec_unit.sv
// Directed bench: full RV32IM unit plus an RV32E build without M sharing the same stimulus.
module tb_rv_exec_unit;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LDO = 7'b0000011;
    localparam logic [6:0] BRO = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] M7  = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, issue_valid;
    logic [31:0] pc, imm, read_data;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    logic        a_ready, a_br, a_busy, a_wb_valid, a_illegal;
    logic [31:0] a_alu, a_rs1_data, a_rs2_data, a_wb_data;
    logic [4:0]  a_wb_rd;
    logic        b_ready, b_br, b_busy, b_wb_valid, b_illegal;
    logic [31:0] b_alu, b_rs1_data, b_rs2_data, b_wb_data;
    logic [4:0]  b_wb_rd;

    int checks = 0;
    int errors = 0;

    rv_exec_unit #(.XLEN(32), .NUM_REGS(32), .ENABLE_M(1)) u_full (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(a_ready),
        .pc(pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .read_data(read_data), .alu_output(a_alu),
        .branch_taken(a_br), .rs1_data(a_rs1_data), .rs2_data(a_rs2_data), .busy(a_busy),
        .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .illegal(a_illegal)
    );

    rv_exec_unit #(.XLEN(32), .NUM_REGS(16), .ENABLE_M(0)) u_e_nom (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(b_ready),
        .pc(pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .read_data(read_data), .alu_output(b_alu),
        .branch_taken(b_br), .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .busy(b_busy),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .illegal(b_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im);
        opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        issue_valid = 1'b1;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic rdreg(input logic [4:0] idx, output logic [31:0] v);
        rs1 = idx;
        #1;
        v = a_rs1_data;
    endtask

    task automatic wr_check(input string tag, input logic [4:0] d, input logic [31:0] exp);
        check(tag, {a_wb_valid, a_wb_rd, a_wb_data}, {1'b1, d, exp});
    endtask

    task automatic m_op(input string tag, input logic [2:0] f3, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] exp);
        int n;
        issue(OPR, f3, M7, d, s1, s2, 32'd0);
        check({tag, "_nom_illegal"}, b_illegal, 1);
        tick;
        check({tag, "_nom_nowb"}, b_wb_valid, 0);
        n = 0;
        while (!a_wb_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 33);
        wr_check({tag, "_wb"}, d, exp);
    endtask

    logic [31:0] v;
    int n, busy_n, ready_low, pulses;

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; pc = 32'h100; imm = '0; read_data = '0;
        opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_wb", {a_wb_valid, a_wb_rd, a_wb_data}, 0);
        rst_n = 1'b1;

        // Immediate arithmetic and compares
        issue(OPI, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check("addi_alu", a_alu, 32'hFFFF_FFFF);
        tick; wr_check("addi_wb", 1, 32'hFFFF_FFFF);
        tick; check("wb_pulse_drop", a_wb_valid, 0);
        issue(OPI, 3'd2, 7'd0, 5'd2, 5'd1, 5'd0, 32'd0);
        tick; wr_check("slti_wb", 2, 32'd1);
        issue(OPI, 3'd3, 7'd0, 5'd3, 5'd1, 5'd0, 32'd1);
        tick; wr_check("sltiu_wb", 3, 32'd0);
        rdreg(5'd2, v); check("x2_read", v, 32'd1);

        // Loads
        read_data = 32'h0000_8001;
        issue(LDO, 3'd1, 7'd0, 5'd4, 5'd0, 5'd0, 32'h10);
        check("lh_addr", a_alu, 32'h10);
        tick; wr_check("lh_wb", 4, 32'hFFFF_8001);
        issue(LDO, 3'd5, 7'd0, 5'd4, 5'd0, 5'd0, 32'h10);
        tick; wr_check("lhu_wb", 4, 32'h0000_8001);
        read_data = 32'h0000_0080;
        issue(LDO, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h3);
        tick; wr_check("lb_wb", 7, 32'hFFFF_FF80);
        issue(OPI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5);
        tick; rdreg(5'd0, v); check("x0_zero", v, 32'd0);

        // Branches, SUB, SRAI
        issue(OPI, 3'd0, 7'h7F, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFE); tick;
        issue(OPI, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd1); tick;
        issue(BRO, 3'd4, 7'd0, 5'd0, 5'd5, 5'd6, 32'd8);
        check("blt_taken", a_br, 1);
        tick; check("branch_nowb", a_wb_valid, 0);
        issue(BRO, 3'd6, 7'd0, 5'd0, 5'd5, 5'd6, 32'd8);
        check("bltu_taken", a_br, 0);
        tick;
        issue(BRO, 3'd5, 7'd0, 5'd0, 5'd6, 5'd6, 32'd8);
        check("bge_eq_taken", a_br, 1);
        tick;
        issue(OPR, 3'd0, 7'b0100000, 5'd8, 5'd6, 5'd5, 32'd0);
        tick; wr_check("sub_wb", 8, 32'd3);
        issue(OPI, 3'd5, 7'b0100000, 5'd9, 5'd5, 5'd0, 32'h0000_0401);
        tick; wr_check("srai_wb", 9, 32'hFFFF_FFFF);

        // MULH timing with an ignored issue while busy
        issue(LUI, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h8000_0000); tick;
        issue(OPR, 3'd1, M7, 5'd11, 5'd10, 5'd10, 32'd0);
        check("mulh_nom_illegal", b_illegal, 1);
        check("mulh_legal", a_illegal, 0);
        tick;
        busy_n = int'(a_busy);
        ready_low = int'(!a_ready);
        n = 0;
        while (!a_wb_valid && n < 40) begin
            if (n == 4) begin
                issue(OPI, 3'd0, 7'd0, 5'd12, 5'd1, 5'd0, 32'd7);
                check("rs1_track_busy", a_rs1_data, 32'hFFFF_FFFF);
            end
            @(posedge clk);
            #1;
            issue_valid = 1'b0;
            n++;
            busy_n += int'(a_busy);
            ready_low += int'(!a_ready);
        end
        check("mulh_latency", n, 33);
        check("mulh_busy_cycles", busy_n, 32);
        check("mulh_ready_low", ready_low, 33);
        wr_check("mulh_wb", 11, 32'h4000_0000);
        rdreg(5'd12, v); check("busy_issue_ignored", v, 32'd0);

        // Multiply variants and divide corner cases
        m_op("mul", 3'd0, 5'd15, 5'd5, 5'd6, 32'hFFFF_FFFE);
        m_op("mulhsu", 3'd2, 5'd15, 5'd5, 5'd1, 32'hFFFF_FFFE);
        m_op("mulhu", 3'd3, 5'd15, 5'd1, 5'd1, 32'hFFFF_FFFE);
        issue(OPI, 3'd0, 7'd0, 5'd13, 5'd0, 5'd0, 32'd7); tick;
        m_op("div_by0", 3'd4, 5'd15, 5'd13, 5'd0, 32'hFFFF_FFFF);
        m_op("rem_by0", 3'd6, 5'd15, 5'd13, 5'd0, 32'd7);
        m_op("div_ovf", 3'd4, 5'd15, 5'd10, 5'd1, 32'h8000_0000);
        m_op("rem_ovf", 3'd6, 5'd15, 5'd10, 5'd1, 32'd0);
        issue(OPI, 3'd0, 7'd0, 5'd18, 5'd0, 5'd0, 32'd100); tick;
        m_op("divu", 3'd5, 5'd15, 5'd18, 5'd13, 32'd14);
        m_op("remu", 3'd7, 5'd15, 5'd18, 5'd13, 32'd2);
        issue(OPI, 3'd0, 7'h7F, 5'd20, 5'd0, 5'd0, 32'hFFFF_FFF9); tick;
        issue(OPI, 3'd0, 7'd0, 5'd21, 5'd0, 5'd0, 32'd2); tick;
        m_op("div_neg", 3'd4, 5'd15, 5'd20, 5'd21, 32'hFFFF_FFFD);
        m_op("rem_neg", 3'd6, 5'd15, 5'd20, 5'd21, 32'hFFFF_FFFF);

        // Reset in the middle of a divide
        issue(OPR, 3'd4, M7, 5'd22, 5'd13, 5'd21, 32'd0);
        tick;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", a_busy, 0);
        check("midrst_ready", a_ready, 1);
        check("midrst_wb", a_wb_valid, 0);
        rdreg(5'd13, v); check("midrst_x13", v, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            pulses += int'(a_wb_valid);
        end
        check("midrst_no_wb", pulses, 0);
        rdreg(5'd22, v); check("midrst_x22", v, 32'd0);

        // RV32E/no-M build: M ops and high indices are illegal
        issue(OPI, 3'd0, 7'h7F, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFE); tick;
        m_op("mul_sq", 3'd0, 5'd5, 5'd5, 5'd5, 32'd4);
        rs1 = 5'd5; #1;
        check("nom_rd_kept", b_rs1_data, 32'hFFFF_FFFE);
        issue(OPI, 3'd0, 7'd0, 5'd16, 5'd0, 5'd0, 32'd1);
        check("e_idx_illegal", b_illegal, 1);
        check("e_idx_alu", b_alu, 32'd0);
        check("full_idx_legal", a_illegal, 0);
        check("full_idx_alu", a_alu, 32'd1);
        tick;
        check("e_idx_nowb", b_wb_valid, 0);
        issue(7'b1111111, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9);
        check("bad_op_illegal", a_illegal, 1);
        check("bad_op_alu", a_alu, 32'd0);
        tick;
        check("bad_op_nowb", a_wb_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
